// File: rtl/spim_pkg.sv
// spim_pkg: register map, CTRL bit positions, engine states and SPI mode constants for spi_master_fifo
package spim_pkg;
  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_DATA  = 2'd1;
  localparam logic [1:0] ADDR_RXLVL = 2'd2;
  localparam logic [1:0] ADDR_TXLVL = 2'd3;
  localparam int CTRL_FLUSH   = 7;
  localparam int CTRL_MODE    = 6;
  localparam int CTRL_K_LSB   = 3;
  localparam int CTRL_TGT_LSB = 0;
  localparam logic MODE0 = 1'b0;
  localparam logic MODE3 = 1'b1;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/spim_fifo.sv
// spim_fifo: byte-wide synchronous FIFO with flush, occupancy level and full/empty flags
module spim_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk6x,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_lvl;
  logic          w_pop, w_push;
  assign empty  = r_lvl == '0;
  assign full   = r_lvl == (AW+1)'(DEPTH);
  assign level  = r_lvl;
  assign rdata  = r_mem[r_rp];
  assign w_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_push = push && (!full || w_pop);
  always_ff @(posedge clk6x or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_lvl <= r_lvl + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk6x)
    if (w_push && !flush) r_mem[r_wp] <= wdata;
endmodule

// File: rtl/spi_master_fifo.sv
// spi_master_fifo: register-mapped SPI master with TX/RX FIFOs, NCS chip-selects, mode 0/3, 2^K divider.
// Define SPIM_DONE_IRQ_EN to build the irq_o done interrupt.
module spi_master_fifo
  import spim_pkg::*;
#(
  parameter int NCS        = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk6x,
  input  logic           rst,
  input  logic [1:0]     reg_addr,
  input  logic           reg_wr_en,
  input  logic           reg_rd_en,
  input  logic [7:0]     data_i,
  output logic [7:0]     data_o,
  output logic           spi_sck,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic [NCS-1:0] cs_n_o
`ifdef SPIM_DONE_IRQ_EN
  ,
  output logic           irq_o
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_t r_state, w_next;
  logic [2:0] r_ctrl_tgt, r_ctrl_k, r_tgt, r_k;
  logic r_ctrl_mode, r_ovf, r_discard, r_sck;
  logic [6:0] r_div;
  logic [3:0] r_half;
  logic [7:0] r_tx, r_rx, w_rd, w_tx_rdata, w_rx_rdata;
  logic [LW-1:0] w_tx_lvl, w_rx_lvl;
  logic w_ctrl_wr, w_data_wr, w_data_rd, w_flush, w_half_end, w_busy;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_rx_push;
  assign w_ctrl_wr  = reg_wr_en && reg_addr == ADDR_CTRL;
  assign w_data_wr  = reg_wr_en && reg_addr == ADDR_DATA;
  assign w_data_rd  = reg_rd_en && reg_addr == ADDR_DATA;
  assign w_flush    = w_ctrl_wr && data_i[CTRL_FLUSH];
  assign w_half_end = r_state == SHIFT && r_div == (7'd1 << r_k) - 7'd1;
  assign w_busy     = r_state != IDLE || !w_tx_empty;
  assign w_rx_push  = r_state == DONE && !r_discard && !w_flush;
  assign spi_sck    = r_sck;
  assign spi_mosi   = r_tx[7];
  for (genvar g = 0; g < NCS; g++) begin : g_cs
    assign cs_n_o[g] = r_tgt != 3'(g + 1);
  end
  assign w_rd = reg_addr == ADDR_CTRL  ? {w_busy, w_rx_empty, w_tx_full, r_ovf, r_ctrl_mode, r_ctrl_tgt} :
                reg_addr == ADDR_DATA  ? (w_rx_empty ? 8'h00 : w_rx_rdata) :
                reg_addr == ADDR_RXLVL ? 8'(w_rx_lvl) : 8'(w_tx_lvl);
  spim_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk6x(clk6x), .rst(rst), .flush(w_flush), .push(w_data_wr), .pop(r_state == LOAD),
    .wdata(data_i), .rdata(w_tx_rdata), .level(w_tx_lvl), .full(w_tx_full), .empty(w_tx_empty)
  );
  spim_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk6x(clk6x), .rst(rst), .flush(w_flush), .push(w_rx_push), .pop(w_data_rd),
    .wdata(r_rx), .rdata(w_rx_rdata), .level(w_rx_lvl), .full(w_rx_full), .empty(w_rx_empty)
  );
  always_ff @(posedge clk6x or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // a flush in the same cycle empties TX, so it must not start another byte
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_tx_empty || w_flush) ? IDLE : LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   w_next = (w_half_end && r_half == 4'd15) ? DONE : SHIFT;
      default: w_next = (w_tx_empty || w_flush) ? IDLE : LOAD;
    endcase
  end
  always_ff @(posedge clk6x or posedge rst) begin
    if (rst) begin
      r_ctrl_tgt  <= '0;
      r_ctrl_k    <= '0;
      r_ctrl_mode <= MODE0;
      r_tgt       <= '0;
      r_k         <= '0;
      r_sck       <= 1'b0;
      r_div       <= '0;
      r_half      <= '0;
      r_tx        <= 8'hFF;
      r_rx        <= '0;
      r_ovf       <= 1'b0;
      r_discard   <= 1'b0;
      data_o      <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_ctrl_tgt  <= data_i[CTRL_TGT_LSB +: 3];
        r_ctrl_k    <= data_i[CTRL_K_LSB +: 3];
        r_ctrl_mode <= data_i[CTRL_MODE];
      end
      if (r_state == IDLE) begin
        r_tgt <= r_ctrl_tgt;
        r_k   <= r_ctrl_k;
        r_sck <= r_ctrl_mode == MODE3;
      end
      if (r_state == LOAD) begin
        r_tx   <= w_tx_rdata;
        r_div  <= '0;
        r_half <= '0;
      end
      if (r_state == SHIFT) begin
        r_div <= w_half_end ? 7'd0 : r_div + 7'd1;
        if (w_half_end) begin
          r_sck  <= ~r_sck;
          r_half <= r_half + 4'd1;
          // rising edge samples; the falling edge after a sample shifts (skips mode-3 leading fall)
          if (!r_sck) r_rx <= {r_rx[6:0], spi_miso};
          else if (r_half != 4'd0) r_tx <= {r_tx[6:0], 1'b1};
        end
      end
      if (w_flush) r_ovf <= 1'b0;
      else if (r_state == DONE && !r_discard && w_rx_full && !w_data_rd) r_ovf <= 1'b1;
      if (r_state == DONE) r_discard <= 1'b0;
      else if (w_flush && r_state != IDLE) r_discard <= 1'b1;
      if (reg_rd_en) data_o <= w_rd;
    end
  end
`ifdef SPIM_DONE_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk6x or posedge rst)
    if (rst) r_irq <= 1'b0;
    else if (w_ctrl_wr || w_data_wr) r_irq <= 1'b0;
    else if (r_state == DONE && w_next == IDLE) r_irq <= 1'b1;
  assign irq_o = r_irq;
`endif
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo: directed tests for spi_master_fifo with MISO looped back as ~MOSI
module tb_spi_master_fifo;
  logic clk6x = 1'b0;
  logic rst = 1'b1;
  logic [1:0] reg_addr = 2'd0;
  logic reg_wr_en = 1'b0, reg_rd_en = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic spi_sck, spi_mosi, spi_miso;
  logic [2:0] cs_n_o;
  int checks = 0, failures = 0, rise_cnt = 0;
  assign spi_miso = ~spi_mosi;
  always #5 clk6x = ~clk6x;
  always @(posedge spi_sck) rise_cnt++;
  spi_master_fifo #(.NCS(3), .FIFO_DEPTH(4)) dut (
    .clk6x(clk6x), .rst(rst), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .data_i(data_i), .data_o(data_o), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .cs_n_o(cs_n_o)
  );
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk6x);
    reg_addr = a;
    data_i = d;
    reg_wr_en = 1'b1;
    @(negedge clk6x);
    reg_wr_en = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk6x);
    reg_addr = a;
    reg_rd_en = 1'b1;
    @(negedge clk6x);
    reg_rd_en = 1'b0;
    d = data_o;
  endtask
  task automatic wait_idle(output bit ok);
    logic [7:0] v;
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      rd(2'd0, v);
      if (!v[7]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset;
    logic [7:0] v;
    @(negedge clk6x);
    checks++; if (cs_n_o !== 3'b111) begin failures++; $display("FAIL reset_cs got=%b exp=111", cs_n_o); end
    checks++; if (spi_sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", spi_sck); end
    checks++; if (spi_mosi !== 1'b1) begin failures++; $display("FAIL reset_mosi got=%b exp=1", spi_mosi); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data_o got=%h exp=00", data_o); end
    rst = 1'b0;
    rd(2'd0, v);
    checks++; if (v !== 8'h40) begin failures++; $display("FAIL reset_ctrl got=%h exp=40", v); end
    rd(2'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_rxlvl got=%h exp=00", v); end
  endtask
  task automatic test_loopback;
    logic [7:0] v;
    bit ok;
    int n;
    wr(2'd0, 8'h21);
    wr(2'd1, 8'h03);
    wr(2'd1, 8'h00);
    wr(2'd1, 8'h00);
    checks++; if (cs_n_o !== 3'b110) begin failures++; $display("FAIL loop_cs got=%b exp=110", cs_n_o); end
    for (int i = 0; i < 100 && spi_sck !== 1'b1; i++) @(negedge clk6x);
    n = 0;
    while (spi_sck === 1'b1 && n < 100) begin
      n++;
      @(negedge clk6x);
    end
    checks++; if (n != 16) begin failures++; $display("FAIL loop_sck_high got=%0d exp=16", n); end
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL loop_idle got=busy exp=idle"); end
    rd(2'd1, v);
    checks++; if (v !== 8'hFC) begin failures++; $display("FAIL loop_rx0 got=%h exp=fc", v); end
    rd(2'd1, v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL loop_rx1 got=%h exp=ff", v); end
    rd(2'd1, v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL loop_rx2 got=%h exp=ff", v); end
    rd(2'd1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL loop_rx_empty got=%h exp=00", v); end
  endtask
  task automatic test_overflow;
    logic [7:0] v;
    logic [7:0] exp_rx [4] = '{8'hEE, 8'hDD, 8'hCC, 8'hBB};
    bit ok;
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h11);
    wr(2'd1, 8'h22);
    wr(2'd1, 8'h33);
    wr(2'd1, 8'h44);
    wr(2'd1, 8'h55);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_idle got=busy exp=idle"); end
    rd(2'd2, v);
    checks++; if (v !== 8'h04) begin failures++; $display("FAIL ovf_rxlvl got=%h exp=04", v); end
    rd(2'd0, v);
    checks++; if (v !== 8'h11) begin failures++; $display("FAIL ovf_ctrl got=%h exp=11", v); end
    for (int i = 0; i < 4; i++) begin
      rd(2'd1, v);
      checks++; if (v !== exp_rx[i]) begin failures++; $display("FAIL ovf_rx%0d got=%h exp=%h", i, v, exp_rx[i]); end
    end
    rd(2'd0, v);
    checks++; if (v !== 8'h51) begin failures++; $display("FAIL ovf_sticky got=%h exp=51", v); end
    wr(2'd1, 8'h66);
    wait_idle(ok);
    rd(2'd2, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL ovf_refill got=%h exp=01", v); end
    wr(2'd0, 8'h81);
    rd(2'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL flush_rxlvl got=%h exp=00", v); end
    rd(2'd0, v);
    checks++; if (v !== 8'h41) begin failures++; $display("FAIL flush_ctrl got=%h exp=41", v); end
  endtask
  task automatic test_mode3;
    logic [7:0] v, bits;
    logic prev;
    bit ok;
    int n;
    wr(2'd0, 8'h42);
    repeat (3) @(negedge clk6x);
    checks++; if (spi_sck !== 1'b1) begin failures++; $display("FAIL m3_idle_sck got=%b exp=1", spi_sck); end
    checks++; if (cs_n_o !== 3'b101) begin failures++; $display("FAIL m3_cs got=%b exp=101", cs_n_o); end
    wr(2'd1, 8'hA5);
    prev = spi_sck;
    bits = 8'h00;
    n = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      @(negedge clk6x);
      if (!prev && spi_sck) begin
        bits = {bits[6:0], spi_mosi};
        n++;
      end
      prev = spi_sck;
    end
    checks++; if (n != 8 || bits !== 8'hA5) begin failures++; $display("FAIL m3_mosi got=%h/%0d exp=a5/8", bits, n); end
    wait_idle(ok);
    rd(2'd1, v);
    checks++; if (v !== 8'h5A) begin failures++; $display("FAIL m3_rx got=%h exp=5a", v); end
    checks++; if (spi_sck !== 1'b1) begin failures++; $display("FAIL m3_end_sck got=%b exp=1", spi_sck); end
  endtask
  task automatic test_target_change;
    logic [7:0] v;
    logic [7:0] exp_rx [3] = '{8'hFE, 8'hFD, 8'hFC};
    int base;
    base = rise_cnt;
    wr(2'd0, 8'h21);
    wr(2'd1, 8'h01);
    wr(2'd1, 8'h02);
    wr(2'd1, 8'h03);
    repeat (50) @(negedge clk6x);
    wr(2'd0, 8'h00);
    for (int i = 0; i < 1500 && cs_n_o === 3'b110; i++) @(negedge clk6x);
    checks++; if (cs_n_o !== 3'b111) begin failures++; $display("FAIL tc_cs_release got=%b exp=111", cs_n_o); end
    checks++; if (rise_cnt - base != 24) begin failures++; $display("FAIL tc_rises got=%0d exp=24", rise_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      rd(2'd1, v);
      checks++; if (v !== exp_rx[i]) begin failures++; $display("FAIL tc_rx%0d got=%h exp=%h", i, v, exp_rx[i]); end
    end
    rd(2'd0, v);
    checks++; if (v !== 8'h40) begin failures++; $display("FAIL tc_ctrl got=%h exp=40", v); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] v;
    int base;
    wr(2'd0, 8'h21);
    wr(2'd1, 8'h00);
    for (int i = 0; i < 100 && spi_sck !== 1'b1; i++) @(negedge clk6x);
    checks++; if (spi_sck !== 1'b1) begin failures++; $display("FAIL rm_shift got=%b exp=1", spi_sck); end
    rst = 1'b1;
    #1;
    checks++; if (cs_n_o !== 3'b111) begin failures++; $display("FAIL rm_cs got=%b exp=111", cs_n_o); end
    checks++; if (spi_sck !== 1'b0) begin failures++; $display("FAIL rm_sck got=%b exp=0", spi_sck); end
    checks++; if (spi_mosi !== 1'b1) begin failures++; $display("FAIL rm_mosi got=%b exp=1", spi_mosi); end
    checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL rm_data_o got=%h exp=00", data_o); end
    repeat (2) @(negedge clk6x);
    rst = 1'b0;
    base = rise_cnt;
    rd(2'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL rm_rxlvl got=%h exp=00", v); end
    rd(2'd3, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL rm_txlvl got=%h exp=00", v); end
    repeat (40) @(negedge clk6x);
    checks++; if (rise_cnt != base || spi_sck !== 1'b0) begin failures++; $display("FAIL rm_no_sck got=%0d exp=0", rise_cnt - base); end
  endtask
  initial begin
    test_reset;
    test_loopback;
    test_overflow;
    test_mode3;
    test_target_change;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
